// File: rtl/ctrl_regs_pkg.sv
// Shared constants for the Mandelbrot control register slave: word offsets,
// CTRL/STATUS bit positions, run-FSM encoding and datapath widths.
package ctrl_regs_pkg;

  // Bus geometry of the s1 QMEM slave port
  localparam int QAW = 12;
  localparam int QDW = 32;
  localparam int QSW = QDW / 8;

  // Datapath widths
  localparam int MAXIT_W = 16;
  localparam int CYC_W   = 32;

  // Word index (adr[4:2]) of each register
  localparam logic [2:0] W_CTRL    = 3'd0;
  localparam logic [2:0] W_STATUS  = 3'd1;
  localparam logic [2:0] W_X0      = 3'd2;
  localparam logic [2:0] W_Y0      = 3'd3;
  localparam logic [2:0] W_STEP    = 3'd4;
  localparam logic [2:0] W_MAXIT   = 3'd5;
  localparam logic [2:0] W_CYCLES  = 3'd6;
  localparam logic [2:0] W_SCRATCH = 3'd7;

  // CTRL bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_DONE = 2;

  // STATUS bit positions
  localparam int STAT_RUN  = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_BUSY = 3;

  // Run FSM encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } run_state_e;

endpackage

// File: rtl/ctrl_regs_if.sv
// QMEM slave bus bundle between the control CPU interconnect and ctrl_regs.
interface ctrl_regs_if
  import ctrl_regs_pkg::*;
#(
  parameter int AW = QAW,
  parameter int DW = QDW,
  parameter int SW = DW / 8
);

  logic [AW-1:0] qs_adr;
  logic          qs_cs;
  logic          qs_we;
  logic [SW-1:0] qs_sel;
  logic [DW-1:0] qs_dat_w;
  logic [DW-1:0] qs_dat_r;
  logic          qs_ack;
  logic          qs_err;

  modport master (
    output qs_adr, qs_cs, qs_we, qs_sel, qs_dat_w,
    input  qs_dat_r, qs_ack, qs_err
  );

  modport slave (
    input  qs_adr, qs_cs, qs_we, qs_sel, qs_dat_w,
    output qs_dat_r, qs_ack, qs_err
  );

endinterface

// File: rtl/ctrl_regs.sv
// Mandelbrot engine control registers: CPU-visible parameter/status registers,
// start/busy/done run FSM, engine cycle counter and level completion interrupt.
// Parameters are shadowed on start so the next frame can be programmed while
// the current one renders.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | engine idle, waiting for CTRL.START write
// S_START | shadows loaded, CYCLES cleared, eng_start pulsed this cycle
// S_RUN   | engine rendering, CYCLES counting, waiting for eng_done
module ctrl_regs
  import ctrl_regs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  ctrl_regs_if.slave          qs,
  output logic                eng_start,
  input  logic                eng_busy,
  input  logic                eng_done,
  output logic [QDW-1:0]      eng_x0,
  output logic [QDW-1:0]      eng_y0,
  output logic [QDW-1:0]      eng_step,
  output logic [MAXIT_W-1:0]  eng_maxit,
  output logic                irq
);

  // Byte-lane write merge: replace only the lanes whose select bit is set
  function automatic logic [QDW-1:0] merge_bytes(input logic [QDW-1:0] old_v,
                                                 input logic [QDW-1:0] new_v,
                                                 input logic [QSW-1:0] sel);
    logic [QDW-1:0] r;
    r = old_v;
    for (int b = 0; b < QSW; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Bus-side registers
  logic               ack_q, err_q;
  logic [QDW-1:0]     dat_r_q;
  logic               irq_en_q, irq_en_d;
  logic [QDW-1:0]     x0_q, x0_d, y0_q, y0_d, step_q, step_d, scratch_q, scratch_d;
  logic [MAXIT_W-1:0] maxit_q, maxit_d;

  // Run-side registers
  run_state_e         state_q;
  logic               eng_start_q;
  logic [QDW-1:0]     sh_x0_q, sh_y0_q, sh_step_q;
  logic [MAXIT_W-1:0] sh_maxit_q;
  logic [CYC_W-1:0]   cycles_q;
  logic               done_q, err_st_q;

  // Decode
  logic           acc, mapped, wr_hit, rd_hit, ctrl_wr, start_req, clr_req;
  logic [2:0]     widx;
  logic [QDW-1:0] rdata;
  logic [QDW-1:0] maxit_merged;
  logic           unused_adr;

  assign unused_adr = ^qs.qs_adr[1:0];

  // Access decode: a request is taken in the cycle cs is high and ack is low
  always_comb begin
    acc       = qs.qs_cs & ~ack_q;
    mapped    = (qs.qs_adr[QAW-1:5] == '0);
    widx      = qs.qs_adr[4:2];
    wr_hit    = acc & qs.qs_we & mapped;
    rd_hit    = acc & ~qs.qs_we & mapped;
    ctrl_wr   = wr_hit & (widx == W_CTRL) & qs.qs_sel[0];
    start_req = ctrl_wr & qs.qs_dat_w[CTRL_START];
    clr_req   = ctrl_wr & qs.qs_dat_w[CTRL_CLR_DONE];
  end

  // Next value of every CPU-writable register
  always_comb begin
    irq_en_d     = irq_en_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    step_d       = step_q;
    maxit_d      = maxit_q;
    scratch_d    = scratch_q;
    maxit_merged = merge_bytes({{(QDW-MAXIT_W){1'b0}}, maxit_q}, qs.qs_dat_w, qs.qs_sel);
    if (ctrl_wr) irq_en_d = qs.qs_dat_w[CTRL_IRQ_EN];
    if (wr_hit) begin
      case (widx)
        W_X0:      x0_d      = merge_bytes(x0_q, qs.qs_dat_w, qs.qs_sel);
        W_Y0:      y0_d      = merge_bytes(y0_q, qs.qs_dat_w, qs.qs_sel);
        W_STEP:    step_d    = merge_bytes(step_q, qs.qs_dat_w, qs.qs_sel);
        W_MAXIT:   maxit_d   = maxit_merged[MAXIT_W-1:0];
        W_SCRATCH: scratch_d = merge_bytes(scratch_q, qs.qs_dat_w, qs.qs_sel);
        default:   ;
      endcase
    end
  end

  // Read mux over the state as it stands in the request cycle
  always_comb begin
    rdata = '0;
    case (widx)
      W_CTRL:    rdata[CTRL_IRQ_EN] = irq_en_q;
      W_STATUS: begin
        rdata[STAT_RUN]  = (state_q != S_IDLE);
        rdata[STAT_DONE] = done_q;
        rdata[STAT_ERR]  = err_st_q;
        rdata[STAT_BUSY] = eng_busy;
      end
      W_X0:      rdata = x0_q;
      W_Y0:      rdata = y0_q;
      W_STEP:    rdata = step_q;
      W_MAXIT:   rdata = {{(QDW-MAXIT_W){1'b0}}, maxit_q};
      W_CYCLES:  rdata = cycles_q;
      W_SCRATCH: rdata = scratch_q;
      default:   rdata = '0;
    endcase
  end

  // Bus response and CPU-programmed registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_r_q   <= '0;
      irq_en_q  <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      step_q    <= '0;
      maxit_q   <= '0;
      scratch_q <= '0;
    end else begin
      ack_q     <= qs.qs_cs & ~ack_q;
      err_q     <= acc & ~mapped;
      dat_r_q   <= rd_hit ? rdata : '0;
      irq_en_q  <= irq_en_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      step_q    <= step_d;
      maxit_q   <= maxit_d;
      scratch_q <= scratch_d;
    end
  end

  // Run FSM with shadow load, cycle counter and sticky DONE/ERR flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      eng_start_q <= 1'b0;
      sh_x0_q     <= '0;
      sh_y0_q     <= '0;
      sh_step_q   <= '0;
      sh_maxit_q  <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      err_st_q    <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            state_q     <= S_START;
            eng_start_q <= 1'b1;
            sh_x0_q     <= x0_q;
            sh_y0_q     <= y0_q;
            sh_step_q   <= step_q;
            sh_maxit_q  <= maxit_q;
            cycles_q    <= '0;
          end
        end
        S_START: state_q <= S_RUN;
        S_RUN: begin
          if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
          if (eng_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // A completion in the same cycle as CLR_DONE keeps DONE set
      if (state_q == S_RUN && eng_done) done_q <= 1'b1;
      else if (clr_req)                 done_q <= 1'b0;

      if (start_req && state_q != S_IDLE) err_st_q <= 1'b1;
      else if (clr_req)                    err_st_q <= 1'b0;
    end
  end

  assign qs.qs_ack   = ack_q;
  assign qs.qs_err   = err_q;
  assign qs.qs_dat_r = dat_r_q;
  assign eng_start   = eng_start_q;
  assign eng_x0      = sh_x0_q;
  assign eng_y0      = sh_y0_q;
  assign eng_step    = sh_step_q;
  assign eng_maxit   = sh_maxit_q;
  assign irq         = done_q & irq_en_q;

endmodule

// File: tb/tb_ctrl_regs.sv
// Directed bench for ctrl_regs: bus accesses push their expected response into
// a scoreboard queue, which is popped and compared when the slave acks.
module tb_ctrl_regs;
  import ctrl_regs_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              eng_start, eng_busy, eng_done, irq;
  logic [31:0]       eng_x0, eng_y0, eng_step;
  logic [15:0]       eng_maxit;

  ctrl_regs_if qs_bus ();

  ctrl_regs dut (
    .clk       (clk),
    .rst       (rst),
    .qs        (qs_bus.slave),
    .eng_start (eng_start),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_x0    (eng_x0),
    .eng_y0    (eng_y0),
    .eng_step  (eng_step),
    .eng_maxit (eng_maxit),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cnt = 0;
  int   ack_cyc = 0;
  int   t_n;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eng_start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus access; eng_done may be pulsed in the request cycle
  task automatic bus(input string tag, input logic we, input logic [11:0] adr,
                     input logic [3:0] sel, input logic [31:0] wdat,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input logic pulse_done);
    exp_t e;
    int   n;
    exp_q.push_back('{dat: exp_rd, err: exp_err, rd: ~we});
    qs_bus.qs_cs    = 1'b1;
    qs_bus.qs_we    = we;
    qs_bus.qs_adr   = adr;
    qs_bus.qs_sel   = sel;
    qs_bus.qs_dat_w = wdat;
    eng_done        = pulse_done;
    tick();
    eng_done = 1'b0;
    n = 0;
    while (qs_bus.qs_ack !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    check({tag, "_ack_lat"}, n, 0);
    if (qs_bus.qs_ack === 1'b1) begin
      ack_cyc = cyc;
      e = exp_q.pop_front();
      if (e.rd) check({tag, "_dat"}, qs_bus.qs_dat_r, e.dat);
      check({tag, "_err"}, {31'd0, qs_bus.qs_err}, {31'd0, e.err});
    end else begin
      void'(exp_q.pop_front());
      check({tag, "_timeout"}, {31'd0, qs_bus.qs_ack}, 32'd1);
    end
    qs_bus.qs_cs = 1'b0;
    qs_bus.qs_we = 1'b0;
    tick();
    check({tag, "_ack_drop"}, {31'd0, qs_bus.qs_ack}, 32'd0);
  endtask

  task automatic wr(input string tag, input logic [11:0] adr, input logic [3:0] sel,
                    input logic [31:0] d, input logic exp_err = 1'b0);
    bus(tag, 1'b1, adr, sel, d, 32'd0, exp_err, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [11:0] adr, input logic [31:0] exp,
                    input logic exp_err = 1'b0);
    bus(tag, 1'b0, adr, 4'h0, 32'd0, exp, exp_err, 1'b0);
  endtask

  initial begin
    qs_bus.qs_cs = 1'b0; qs_bus.qs_we = 1'b0; qs_bus.qs_adr = '0;
    qs_bus.qs_sel = '0; qs_bus.qs_dat_w = '0;
    eng_busy = 1'b0; eng_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_ack", {31'd0, qs_bus.qs_ack}, 32'd0);
    check("rst_start", {31'd0, eng_start}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_maxit", {16'd0, eng_maxit}, 32'd0);
    rd("rst_status", 12'h004, 32'h0);
    rd("rst_ctrl", 12'h000, 32'h0);

    // Byte-lane write merge, adr[1:0] ignored
    wr("x0_wr", 12'h008, 4'b0011, 32'h1234_5678);
    rd("x0_rd", 12'h008, 32'h0000_5678);
    wr("y0_wr", 12'h00C, 4'hF, 32'h1111_2222);
    wr("step_wr", 12'h010, 4'hF, 32'h0000_0010);
    wr("maxit_wr", 12'h014, 4'hF, 32'hABCD_00FF);
    rd("maxit_rd", 12'h017, 32'h0000_00FF);

    // Run 1: start with IRQ_EN, exactly 100 RUN cycles
    wr("start1", 12'h000, 4'h1, 32'h3);
    t_n = ack_cyc;
    check("start1_pulse", start_cnt, 1);
    check("sh_x0", eng_x0, 32'h0000_5678);
    check("sh_y0", eng_y0, 32'h1111_2222);
    check("sh_step", eng_step, 32'h0000_0010);
    check("sh_maxit", {16'd0, eng_maxit}, 32'h0000_00FF);
    wr("x0_rewr", 12'h008, 4'hF, 32'hDEAD_BEEF);
    check("sh_x0_kept", eng_x0, 32'h0000_5678);
    while (cyc < t_n + 100) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("done_irq", {31'd0, irq}, 32'd1);
    rd("done_status", 12'h004, 32'h2);
    rd("cycles", 12'h018, 32'd100);
    check("start1_single", start_cnt, 1);
    wr("clr_done", 12'h000, 4'h1, 32'h4);
    check("clr_irq", {31'd0, irq}, 32'd0);
    rd("clr_status", 12'h004, 32'h0);

    // Run 2: START while running sets ERR; done coincident with CLR_DONE
    wr("start2", 12'h000, 4'h1, 32'h1);
    check("start2_pulse", start_cnt, 2);
    check("sh_x0_new", eng_x0, 32'hDEAD_BEEF);
    wr("start_busy", 12'h000, 4'h1, 32'h1);
    eng_busy = 1'b1;
    rd("err_status", 12'h004, 32'hD);
    eng_busy = 1'b0;
    check("no_second_start", start_cnt, 2);
    bus("clr_vs_done", 1'b1, 12'h000, 4'h1, 32'h4, 32'h0, 1'b0, 1'b1);
    rd("setwins_status", 12'h004, 32'h2);
    wr("irq_en", 12'h000, 4'h1, 32'h2);
    rd("ctrl_rd", 12'h000, 32'h2);
    check("irq_level", {31'd0, irq}, 32'd1);
    wr("ro_status_wr", 12'h004, 4'hF, 32'hFFFF_FFFF);
    rd("ro_status_rd", 12'h004, 32'h2);

    // Unmapped accesses
    wr("scr_wr", 12'h01C, 4'hF, 32'hA5A5_5A5A);
    rd("unm_rd", 12'h020, 32'h0, 1'b1);
    wr("unm_wr", 12'h020, 4'hF, 32'hFFFF_FFFF, 1'b1);
    wr("unm_wr_alias", 12'h03C, 4'hF, 32'h0BAD_0BAD, 1'b1);
    wr("unm_ctrl_alias", 12'h820, 4'hF, 32'h1, 1'b1);
    rd("unm_rd_hi", 12'h800, 32'h0, 1'b1);
    check("unm_no_start", start_cnt, 2);
    rd("scr_rd", 12'h01F, 32'hA5A5_5A5A);
    rd("x0_after_unm", 12'h008, 32'hDEAD_BEEF);

    // Reset mid-run
    wr("start3", 12'h000, 4'h1, 32'h7);
    check("start3_pulse", start_cnt, 3);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("rst_run_x0", eng_x0, 32'h0);
    check("rst_run_maxit", {16'd0, eng_maxit}, 32'h0);
    check("rst_run_irq", {31'd0, irq}, 32'd0);
    check("rst_run_start", {31'd0, eng_start}, 32'd0);
    check("rst_run_datr", qs_bus.qs_dat_r, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    repeat (4) tick();
    check("rst_no_start", start_cnt, 3);
    rd("rst_run_status", 12'h004, 32'h0);
    rd("rst_run_x0_reg", 12'h008, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ctrl_regs.md
# ctrl_regs

Register slave on port s1 of the control-CPU QMEM interconnect (byte window 0x2000–0x2fff as seen by the CPU). It holds the Mandelbrot engine parameters and runs the start/busy/done handshake with the engine through a small run FSM. It also counts engine cycles and raises a level interrupt on completion. Parameter registers are shadowed at start, so the CPU may reprogram the next frame while the current one renders.

## Interface
- QAW, 12, slave byte-address width
- QDW, 32, data width
- QSW, QDW/8, byte-select width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- qs_adr  in  QAW  byte address
- qs_cs  in  1  access request; held until qs_ack
- qs_we  in  1  1=write, 0=read
- qs_sel  in  QSW  byte write enables
- qs_dat_w  in  QDW  write data
- qs_dat_r  out  QDW  read data, valid while qs_ack
- qs_ack  out  1  one-cycle access acknowledge
- qs_err  out  1  unmapped access, valid with qs_ack
- eng_start  out  1  one-cycle start pulse to the engine
- eng_busy  in  1  engine running (informational, shown in STATUS)
- eng_done  in  1  one-cycle completion pulse from the engine
- eng_x0 / eng_y0 / eng_step  out  32 each  shadowed parameters
- eng_maxit  out  16  shadowed iteration limit
- irq  out  1  done & irq_en

## Operation
- Word decode uses adr[4:2]. adr[1:0] is ignored. adr[QAW-1:5]≠0 is unmapped.
- 0x00 CTRL (RW)
  - bit0 START: write-1 requests a run; self-clearing, reads 0
  - bit1 IRQ_EN: RW
  - bit2 CLR_DONE: write-1 clears DONE; reads 0
- 0x04 STATUS (RO)
  - bit0 RUN: FSM not IDLE
  - bit1 DONE: sticky
  - bit2 ERR: sticky, set by START while not IDLE; cleared by CLR_DONE
  - bit3 eng_busy
- 0x08 X0, 0x0C Y0, 0x10 STEP: 32-bit RW.
- 0x14 MAXIT: RW, bits[15:0]; upper bits read 0.
- 0x18 CYCLES (RO): engine cycle count.
- 0x1C SCRATCH: 32-bit RW.
- Writes honour qs_sel per byte. Writes to RO registers are acked and ignored.
- Unmapped access: qs_ack=1, qs_err=1, qs_dat_r=0, no side effects.
- FSM IDLE → START on an accepted CTRL write with sel[0]=1 and dat_w[0]=1.
  - Entering START: X0/Y0/STEP/MAXIT are copied to the eng_* shadows and CYCLES is cleared to 0.
- FSM START → RUN unconditionally. eng_start=1 only in START.
- RUN: CYCLES increments by 1 per cycle, saturating at 0xFFFF_FFFF.
- RUN → IDLE on eng_done, which sets DONE.
- START request while in START or RUN: ignored, ERR set.
- Same-cycle DONE set and CLR_DONE: set wins, DONE=1, ERR cleared.
- eng_done outside RUN: ignored.

## Timing
- qs_ack is registered: qs_ack <= qs_cs & ~qs_ack.
  - Ack comes 1 cycle after qs_cs is sampled and lasts exactly 1 cycle.
  - Maximum rate is one access per 2 cycles.
- Write effects land on the clock edge that raises qs_ack.
- Read data is registered alongside qs_ack and reflects register state at the request cycle.
- Start sequence relative to the CTRL.START write acknowledge (edge n):
  - FSM is in START during cycle n.
  - eng_start is high in cycle n.
  - RUN begins at n+1.
- Done sequence: eng_done in cycle m → IDLE and DONE=1 from m+1 → irq=1 from m+1 if IRQ_EN.
- Reset values:
  - qs_ack, qs_err, qs_dat_r = 0
  - eng_start = 0
  - all eng_* shadows = 0
  - irq = 0
  - FSM = IDLE
  - all registers = 0
- Asserting rst mid-run returns to IDLE immediately. No eng_start is emitted after release until a new START write.

## Structure
- Package ctrl_regs_pkg holds:
  - register word offsets (CTRL..SCRATCH)
  - CTRL and STATUS bit positions
  - FSM state encoding (IDLE, START, RUN)
  - widths MAXIT_W=16, CYC_W=32
- Single module, no sub-modules. The byte-lane write-merge helper is a local function.

## Test plan
- Write X0=0x1234_5678 with sel=4'b0011, then read → 0x0000_5678. Ack 1 cycle after cs, err=0.
- Program X0/Y0/STEP/MAXIT=0x00FF, write CTRL=0x3 → one eng_start pulse the following cycle.
  - eng_maxit=0x00FF.
  - Rewriting X0 during RUN leaves eng_x0 unchanged.
- In RUN for 100 cycles then pulse eng_done → CYCLES=100, STATUS=0x2, irq=1.
  - Write CTRL=0x4 → DONE=0, irq=0.
- Write CTRL.START during RUN → no second eng_start, STATUS.ERR=1. eng_done in the same cycle as CLR_DONE → DONE=1.
- Read address 0x020 → ack with err=1, dat_r=0. Write 0x020 → no register changes.
- Assert rst during RUN → all outputs 0, FSM IDLE. A subsequent eng_done does not set DONE.
